ps2_key_decoder: RTL and testbench



---
 rtl/tron_keys_pkg.sv | 86 ++++++++
 rtl/ps2_rx.sv | 123 ++++++++++++
 rtl/ps2_key_decoder.sv | 84 ++++++++
 tb/tb_ps2_key_decoder.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tron_keys_pkg.sv
// Shared Tron keyboard definitions: PS/2 scan codes, game key codes,
// direction encoding, and the make-code lookup used by the key decoder.
package tron_keys_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    // Arrow keys (after E0) and keypad 8/2/4/6 (no prefix) share make-codes.
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_I     = 8'h43;
    localparam logic [7:0] SC_K     = 8'h42;
    localparam logic [7:0] SC_J     = 8'h3B;
    localparam logic [7:0] SC_L     = 8'h4B;
    localparam logic [7:0] SC_SPACE = 8'h29;

    localparam logic [4:0] KEY_ARROW_UP    = 5'd0;
    localparam logic [4:0] KEY_ARROW_DOWN  = 5'd1;
    localparam logic [4:0] KEY_ARROW_LEFT  = 5'd2;
    localparam logic [4:0] KEY_ARROW_RIGHT = 5'd3;
    localparam logic [4:0] KEY_W           = 5'd4;
    localparam logic [4:0] KEY_S           = 5'd5;
    localparam logic [4:0] KEY_A           = 5'd6;
    localparam logic [4:0] KEY_D           = 5'd7;
    localparam logic [4:0] KEY_I           = 5'd8;
    localparam logic [4:0] KEY_K           = 5'd9;
    localparam logic [4:0] KEY_J           = 5'd10;
    localparam logic [4:0] KEY_L           = 5'd11;
    localparam logic [4:0] KEY_KP_UP       = 5'd12;
    localparam logic [4:0] KEY_KP_DOWN     = 5'd13;
    localparam logic [4:0] KEY_KP_LEFT     = 5'd14;
    localparam logic [4:0] KEY_KP_RIGHT    = 5'd15;
    localparam logic [4:0] KEY_SPACE       = 5'd16;
    localparam logic [4:0] KEY_IDLE_CODE   = 5'd31;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    typedef struct packed {
        logic       hit;
        logic [4:0] code;
    } key_lookup_t;

    function automatic key_lookup_t lookup_key(input logic ext, input logic [7:0] sc);
        key_lookup_t r;
        r.hit  = 1'b1;
        r.code = KEY_IDLE_CODE;
        if (ext) begin
            case (sc)
                SC_UP:    r.code = KEY_ARROW_UP;
                SC_DOWN:  r.code = KEY_ARROW_DOWN;
                SC_LEFT:  r.code = KEY_ARROW_LEFT;
                SC_RIGHT: r.code = KEY_ARROW_RIGHT;
                default:  r.hit  = 1'b0;
            endcase
        end else begin
            case (sc)
                SC_W:     r.code = KEY_W;
                SC_S:     r.code = KEY_S;
                SC_A:     r.code = KEY_A;
                SC_D:     r.code = KEY_D;
                SC_I:     r.code = KEY_I;
                SC_K:     r.code = KEY_K;
                SC_J:     r.code = KEY_J;
                SC_L:     r.code = KEY_L;
                SC_UP:    r.code = KEY_KP_UP;
                SC_DOWN:  r.code = KEY_KP_DOWN;
                SC_LEFT:  r.code = KEY_KP_LEFT;
                SC_RIGHT: r.code = KEY_KP_RIGHT;
                SC_SPACE: r.code = KEY_SPACE;
                default:  r.hit  = 1'b0;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 byte receiver: synchronises the raw lines, frames start/8 data/parity/stop
// on falling PS/2 clock edges, and aborts a stalled frame via a watchdog.
module ps2_rx #(
    parameter int unsigned TIMEOUT_CYCLES = 10000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    logic            clk_meta_q, clk_sync_q, clk_prev_q;
    logic            dat_meta_q, dat_sync_q;
    logic [1:0]      state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            parity_q, parity_d;
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            byte_valid_q, byte_valid_d;
    logic            frame_err_q, frame_err_d;
    logic            fall;

    assign fall = clk_prev_q & ~clk_sync_q;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path can infer a latch.
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        if (state_q == ST_IDLE || fall) begin
            wdog_d = '0;
        end else begin
            wdog_d = wdog_q + 1'b1;
        end

        if (state_q != ST_IDLE && wdog_q == WD_LIMIT) begin
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
            wdog_d      = '0;
        end else if (fall) begin
            case (state_q)
                ST_IDLE: begin
                    // A high data bit here is line noise, not a start bit.
                    if (!dat_sync_q) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    shift_d   = {dat_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    parity_d = dat_sync_q;
                    state_d  = ST_STOP;
                end
                ST_STOP: begin
                    if (dat_sync_q && (^{shift_q, parity_q})) begin
                        byte_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_meta_q   <= 1'b1;
            clk_sync_q   <= 1'b1;
            clk_prev_q   <= 1'b1;
            dat_meta_q   <= 1'b1;
            dat_sync_q   <= 1'b1;
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            wdog_q       <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            clk_meta_q   <= ps2_clk_i;
            clk_sync_q   <= clk_meta_q;
            clk_prev_q   <= clk_sync_q;
            dat_meta_q   <= ps2_dat_i;
            dat_sync_q   <= dat_meta_q;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            wdog_q       <= wdog_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign byte_o       = shift_q;
    assign byte_valid_o = byte_valid_q;
    assign frame_err_o  = frame_err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// Turns received PS/2 bytes into one-cycle game key pulses, honouring the
// E0 (extended) and F0 (break) prefixes; feeds mechanics.key_in.
module ps2_key_decoder
    import tron_keys_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 10000,
    parameter logic [4:0]  IDLE_CODE      = KEY_IDLE_CODE
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       PS2_KBCLK,
    input  logic       PS2_KBDAT,
    output logic [4:0] KEY_PRESSED,
    output logic       key_valid,
    output logic       frame_err
);

    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        rx_err;
    logic        ext_q, ext_d;
    logic        brk_q, brk_d;
    logic [4:0]  key_q, key_d;
    logic        valid_q, valid_d;
    key_lookup_t lut;

    ps2_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk          (CLOCK_50),
        .rst_n        (resetn),
        .ps2_clk_i    (PS2_KBCLK),
        .ps2_dat_i    (PS2_KBDAT),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_valid),
        .frame_err_o  (rx_err)
    );

    assign lut = lookup_key(ext_q, rx_byte);

    always_comb begin
        ext_d   = ext_q;
        brk_d   = brk_q;
        key_d   = IDLE_CODE;
        valid_d = 1'b0;
        // A discarded frame may have been part of a prefix sequence; start clean.
        if (rx_err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (rx_valid) begin
            if (rx_byte == SC_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == SC_BRK) begin
                brk_d = 1'b1;
            end else begin
                if (!brk_q && lut.hit) begin
                    key_d   = lut.code;
                    valid_d = 1'b1;
                end
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            key_q   <= IDLE_CODE;
            valid_q <= 1'b0;
        end else begin
            ext_q   <= ext_d;
            brk_q   <= brk_d;
            key_q   <= key_d;
            valid_q <= valid_d;
        end
    end

    assign KEY_PRESSED = key_q;
    assign key_valid   = valid_q;
    assign frame_err   = rx_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: a scan-code-level model predicts
// key pulses and frame errors; a per-cycle compare process checks the DUT.
module tb_ps2_key_decoder;

    logic       clk;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [4:0] key_pressed;
    logic       key_valid;
    logic       frame_err;

    ps2_key_decoder #(
        .TIMEOUT_CYCLES(10000),
        .IDLE_CODE     (5'd31)
    ) dut (
        .CLOCK_50   (clk),
        .resetn     (rst_n),
        .PS2_KBCLK  (ps2_clk),
        .PS2_KBDAT  (ps2_dat),
        .KEY_PRESSED(key_pressed),
        .key_valid  (key_valid),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        int cyc;
        int code;
    } exp_t;

    int   n_vec = 0;
    int   n_mis = 0;
    int   cyc = 0;
    int   last_fall = 0;
    exp_t kq[$];
    int   fq[$];
    bit   ferr_chk = 1'b1;
    int   pulses = 0;
    int   last_key = -1;
    int   ferr_seen = 0;
    int   map_plain[256];
    int   map_ext[256];
    bit   m_ext = 1'b0;
    bit   m_brk = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Per-cycle compare against the model's expectation queues.
    always @(posedge clk) begin
        int exp_valid;
        int exp_key;
        int exp_ferr;
        #1;
        exp_valid = 0;
        exp_key   = 31;
        while (kq.size() > 0 && kq[0].cyc < cyc) begin
            check("key_pulse_missed", 0, 1);
            void'(kq.pop_front());
        end
        if (kq.size() > 0 && kq[0].cyc == cyc) begin
            exp_valid = 1;
            exp_key   = kq[0].code;
            void'(kq.pop_front());
        end
        check("key_valid", int'(key_valid), exp_valid);
        check("KEY_PRESSED", int'(key_pressed), exp_key);
        if (ferr_chk) begin
            exp_ferr = 0;
            while (fq.size() > 0 && fq[0] < cyc) begin
                check("frame_err_missed", 0, 1);
                void'(fq.pop_front());
            end
            if (fq.size() > 0 && fq[0] == cyc) begin
                exp_ferr = 1;
                void'(fq.pop_front());
            end
            check("frame_err", int'(frame_err), exp_ferr);
        end
        if (key_valid) begin
            pulses++;
            last_key = int'(key_pressed);
        end
        if (frame_err) ferr_seen++;
    end

    // Two synchroniser flops, edge seen at N, byte at N+1, key at N+2.
    task automatic model_stop(input logic [7:0] b, input bit ok, input int k);
        int c;
        if (!ok) begin
            fq.push_back(k + 3);
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            c = m_ext ? map_ext[b] : map_plain[b];
            if (!m_brk && c >= 0) kq.push_back('{cyc: k + 4, code: c});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic bit_fall(input logic b);
        @(negedge clk);
        ps2_dat = b;
        repeat (8) @(negedge clk);
        ps2_clk   = 1'b0;
        last_fall = cyc;
    endtask

    task automatic bit_rise();
        repeat (16) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (7) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par);
        logic [10:0] bits;
        logic        par;
        par  = ~(^b) ^ bad_par;
        bits = {1'b1, par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            bit_fall(bits[i]);
            if (i == 10) model_stop(b, !bad_par, last_fall);
            bit_rise();
        end
        repeat (40) @(negedge clk);
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits);
        bit_fall(1'b0);
        bit_rise();
        for (int i = 0; i < nbits; i++) begin
            bit_fall(b[i]);
            bit_rise();
        end
    endtask

    initial begin
        int p0;
        int f0;
        int d;
        bit got;

        for (int i = 0; i < 256; i++) begin
            map_plain[i] = -1;
            map_ext[i]   = -1;
        end
        map_ext[8'h75] = 0;   map_ext[8'h72] = 1;   map_ext[8'h6B] = 2;   map_ext[8'h74] = 3;
        map_plain[8'h1D] = 4; map_plain[8'h1B] = 5; map_plain[8'h1C] = 6; map_plain[8'h23] = 7;
        map_plain[8'h43] = 8; map_plain[8'h42] = 9; map_plain[8'h3B] = 10; map_plain[8'h4B] = 11;
        map_plain[8'h75] = 12; map_plain[8'h72] = 13; map_plain[8'h6B] = 14; map_plain[8'h74] = 15;
        map_plain[8'h29] = 16;

        rst_n   = 1'b0;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_KEY_PRESSED", int'(key_pressed), 31);
        check("rst_key_valid", int'(key_valid), 0);
        check("rst_frame_err", int'(frame_err), 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        p0 = pulses;
        send_frame(8'h1D, 1'b0);
        check("lit_1D_count", pulses - p0, 1);
        check("lit_1D_code", last_key, 4);

        // Typematic repeat: a second make produces a second pulse.
        p0 = pulses;
        send_frame(8'h1D, 1'b0);
        check("lit_repeat_count", pulses - p0, 1);

        send_frame(8'hE0, 1'b0);
        send_frame(8'h75, 1'b0);
        check("lit_E0_75", last_key, 0);
        send_frame(8'h75, 1'b0);
        check("lit_75", last_key, 12);

        p0 = pulses;
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        check("lit_break_silent", pulses - p0, 0);
        send_frame(8'h75, 1'b0);
        check("lit_prefix_cleared", last_key, 12);

        p0 = pulses;
        send_frame(8'hF0, 1'b0);
        send_frame(8'h29, 1'b0);
        check("lit_F0_29_silent", pulses - p0, 0);
        send_frame(8'h29, 1'b0);
        check("lit_space_count", pulses - p0, 1);
        check("lit_space_code", last_key, 16);

        // Unmapped byte and a spurious high-data edge in IDLE: silent, no error.
        p0 = pulses;
        f0 = ferr_seen;
        send_frame(8'h5A, 1'b0);
        bit_fall(1'b1);
        bit_rise();
        repeat (40) @(negedge clk);
        check("lit_unmapped_silent", pulses - p0, 0);
        check("lit_idle_noise_noerr", ferr_seen - f0, 0);

        p0 = pulses;
        f0 = ferr_seen;
        send_frame(8'h23, 1'b1);
        check("lit_badpar_err", ferr_seen - f0, 1);
        check("lit_badpar_nokey", pulses - p0, 0);
        send_frame(8'h23, 1'b0);
        check("lit_D_after_err", last_key, 7);

        // E0 then a broken frame: the error must drop the pending prefix.
        send_frame(8'hE0, 1'b0);
        send_frame(8'h11, 1'b1);
        send_frame(8'h72, 1'b0);
        check("lit_err_clears_ext", last_key, 13);

        // Watchdog: stall after 4 data bits.
        send_frame(8'hE0, 1'b0);
        send_partial(8'h43, 4);
        ferr_chk = 1'b0;
        got = 1'b0;
        d = 0;
        for (int i = 0; i < 11000 && !got; i++) begin
            @(posedge clk);
            #1;
            if (frame_err) begin
                got = 1'b1;
                d = cyc - last_fall;
            end
        end
        check("timeout_seen", int'(got), 1);
        check("timeout_window", int'(d >= 9995 && d <= 10010), 1);
        @(posedge clk);
        #1;
        check("timeout_pulse_len", int'(frame_err), 0);
        m_ext = 1'b0;
        m_brk = 1'b0;
        @(negedge clk);
        ferr_chk = 1'b1;
        send_frame(8'h43, 1'b0);
        check("lit_I_after_timeout", last_key, 8);

        // Reset mid-frame, then a clean frame.
        p0 = pulses;
        f0 = ferr_seen;
        send_partial(8'h42, 4);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_KEY_PRESSED", int'(key_pressed), 31);
        check("midrst_key_valid", int'(key_valid), 0);
        check("midrst_frame_err", int'(frame_err), 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(8'h3B, 1'b0);
        check("lit_midrst_count", pulses - p0, 1);
        check("lit_midrst_code", last_key, 10);
        check("lit_midrst_noerr", ferr_seen - f0, 0);

        repeat (10) @(negedge clk);
        check("key_queue_drained", kq.size(), 0);
        check("err_queue_drained", fq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench time limit");
    end

endmodule
